// File: rtl/rr_wormhole_arbiter.sv
// Round-robin wormhole arbiter for one router output port: zero-cycle combinational grant, lock held head-to-tail.
// Backpressure: buffer_full_in blocks every transfer; an IDLE arbiter commits to no winner while full.
module rr_wormhole_arbiter #(
    parameter int N       = 3,
    parameter int STALL_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         request,
    input  logic [N-1:0]         tail_i,
    input  logic                 buffer_full_in,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx_o,
    output logic                 grant_v_o,
    output logic                 locked_o,
    output logic [STALL_W-1:0]   stall_cnt_o
);
    localparam int IDX_W = $clog2(N);
    localparam logic [IDX_W:0] N_EXT = (IDX_W+1)'(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N-1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCKED = 2'd1
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic [IDX_W-1:0]   win_idx;
    logic               win_found;
    logic [IDX_W:0]     cand;
    logic               pending;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (i == LAST_IDX) ? '0 : i + 1'b1;
    endfunction

    // First requester at or after ptr, wrapping modulo N.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, ptr_q} + (IDX_W+1)'(k);
            if (cand >= N_EXT) begin
                cand = cand - N_EXT;
            end
            if (!win_found && request[cand[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        grant       = '0;
        grant_idx_o = '0;
        grant_v_o   = 1'b0;
        pending     = 1'b0;
        case (state_q)
            IDLE: begin
                pending = win_found;
                if (win_found && !buffer_full_in) begin
                    grant[win_idx] = 1'b1;
                    grant_idx_o    = win_idx;
                    grant_v_o      = 1'b1;
                end
            end
            LOCKED: begin
                grant[owner_q] = 1'b1;
                grant_idx_o    = owner_q;
                grant_v_o      = request[owner_q] & ~buffer_full_in;
                pending        = request[owner_q];
            end
            default: begin
                pending = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        case (state_q)
            IDLE: begin
                if (grant_v_o) begin
                    if (tail_i[win_idx]) begin
                        ptr_d = next_idx(win_idx);
                    end else begin
                        state_d = LOCKED;
                        owner_d = win_idx;
                    end
                end
            end
            LOCKED: begin
                if (grant_v_o && tail_i[owner_q]) begin
                    state_d = IDLE;
                    ptr_d   = next_idx(owner_q);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A transfer implies !buffer_full_in, so it clears the counter through the same path.
    always_comb begin
        stall_d = '0;
        if (buffer_full_in && pending) begin
            stall_d = (&stall_q) ? stall_q : stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            stall_q <= stall_d;
        end
    end

    assign locked_o    = (state_q == LOCKED);
    assign stall_cnt_o = stall_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert ($onehot0(grant));
            assert (!grant_v_o || (request[grant_idx_o] && !buffer_full_in));
            assert (int'(owner_q) < N);
            assert (state_q != LOCKED || grant == (N'(1) << owner_q));
            assert (state_q != LOCKED || owner_d == owner_q);
        end
    end

endmodule

// File: tb/tb_rr_wormhole_arbiter.sv
// Directed test-plan steps followed by random traffic, checked against a behavioural model of the arbitration rules.
module tb_rr_wormhole_arbiter;
    localparam int N  = 3;
    localparam int IW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  request;
    logic [N-1:0]  tail_i;
    logic          buffer_full_in;

    logic [N-1:0]  grant_a, grant_b;
    logic [IW-1:0] idx_a, idx_b;
    logic          v_a, v_b, lk_a, lk_b;
    logic [7:0]    st_a;
    logic [1:0]    st_b;

    rr_wormhole_arbiter #(.N(N), .STALL_W(8)) dut_a (
        .clk(clk), .rst(rst), .request(request), .tail_i(tail_i),
        .buffer_full_in(buffer_full_in), .grant(grant_a), .grant_idx_o(idx_a),
        .grant_v_o(v_a), .locked_o(lk_a), .stall_cnt_o(st_a)
    );

    rr_wormhole_arbiter #(.N(N), .STALL_W(2)) dut_b (
        .clk(clk), .rst(rst), .request(request), .tail_i(tail_i),
        .buffer_full_in(buffer_full_in), .grant(grant_b), .grant_idx_o(idx_b),
        .grant_v_o(v_b), .locked_o(lk_b), .stall_cnt_o(st_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: packet-level state (lock, owner, pointer, stall counts).
    bit           m_locked;
    int           m_owner, m_ptr, m_win, m_st8, m_st2;
    logic [N-1:0] e_grant;
    int           e_idx;
    bit           e_v;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_locked = 0; m_owner = 0; m_ptr = 0; m_win = -1; m_st8 = 0; m_st2 = 0;
    endtask

    task automatic model_expect();
        e_grant = '0; e_idx = 0; e_v = 0; m_win = -1;
        if (!m_locked) begin
            for (int k = 0; k < N; k++) begin
                if (m_win < 0 && request[(m_ptr + k) % N]) m_win = (m_ptr + k) % N;
            end
            if (m_win >= 0 && !buffer_full_in) begin
                e_grant[m_win] = 1'b1; e_idx = m_win; e_v = 1;
            end
        end else begin
            e_grant[m_owner] = 1'b1;
            e_idx = m_owner;
            e_v = request[m_owner] && !buffer_full_in;
        end
    endtask

    task automatic model_update();
        bit pend;
        pend = m_locked ? request[m_owner] : (request != '0);
        if (buffer_full_in && pend) begin
            m_st8 = (m_st8 < 255) ? m_st8 + 1 : 255;
            m_st2 = (m_st2 < 3) ? m_st2 + 1 : 3;
        end else begin
            m_st8 = 0; m_st2 = 0;
        end
        if (e_v) begin
            if (m_locked) begin
                if (tail_i[m_owner]) begin
                    m_locked = 0; m_ptr = (m_owner + 1) % N;
                end
            end else if (tail_i[m_win]) begin
                m_ptr = (m_win + 1) % N;
            end else begin
                m_locked = 1; m_owner = m_win;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_grant_a"}, 32'(grant_a), 32'(e_grant));
        chk({tag, "_idx_a"},   32'(idx_a),   32'(e_idx));
        chk({tag, "_v_a"},     32'(v_a),     32'(e_v));
        chk({tag, "_lock_a"},  32'(lk_a),    32'(m_locked));
        chk({tag, "_stall_a"}, 32'(st_a),    32'(m_st8));
        chk({tag, "_grant_b"}, 32'(grant_b), 32'(e_grant));
        chk({tag, "_v_b"},     32'(v_b),     32'(e_v));
        chk({tag, "_lock_b"},  32'(lk_b),    32'(m_locked));
        chk({tag, "_stall_b"}, 32'(st_b),    32'(m_st2));
        chk({tag, "_onehot"},  32'($onehot0(grant_a)), 32'd1);
    endtask

    // Entered just after a rising edge; inputs held until the next step.
    task automatic step(input logic [N-1:0] r, input logic [N-1:0] t, input logic f,
                        input string tag, input int ci = -1, input int cv = -1,
                        input int cl = -1, input int cs = -1, input int cs2 = -1);
        request = r; tail_i = t; buffer_full_in = f;
        #2;
        model_expect();
        check_all(tag);
        if (ci >= 0)  chk({tag, "_plan_idx"},    32'(idx_a), 32'(ci));
        if (cv >= 0)  chk({tag, "_plan_v"},      32'(v_a),   32'(cv));
        if (cl >= 0)  chk({tag, "_plan_lock"},   32'(lk_a),  32'(cl));
        if (cs >= 0)  chk({tag, "_plan_stall"},  32'(st_a),  32'(cs));
        if (cs2 >= 0) chk({tag, "_plan_stall2"}, 32'(st_b),  32'(cs2));
        @(posedge clk);
        model_update();
        #1;
    endtask

    // Asserts reset asynchronously with current inputs still applied.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        model_reset();
        model_expect();
        check_all(tag);
        chk({tag, "_async_lock"},  32'(lk_a), 32'd0);
        chk({tag, "_async_stall"}, 32'(st_a), 32'd0);
        request = '0; tail_i = '0; buffer_full_in = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    int burst;
    logic [N-1:0] rr, rt;
    logic rf;

    initial begin
        rst = 1'b0; request = '0; tail_i = '0; buffer_full_in = 1'b0;
        model_reset();
        #1;
        do_reset("rst0");

        step(3'b111, 3'b111, 1'b0, "tp1", 0, 1, 0);
        step(3'b111, 3'b111, 1'b0, "tp1", 1, 1, 0);
        step(3'b111, 3'b111, 1'b0, "tp1", 2, 1, 0);
        step(3'b111, 3'b111, 1'b0, "tp1", 0, 1, 0);

        do_reset("rst1");
        step(3'b011, 3'b000, 1'b0, "tp2", 0, 1, 0);
        step(3'b011, 3'b000, 1'b0, "tp2", 0, 1, 1);
        step(3'b011, 3'b001, 1'b0, "tp2", 0, 1, 1);
        step(3'b011, 3'b000, 1'b0, "tp2", 1, 1, 0);

        step(3'b101, 3'b000, 1'b0, "tp3gap", 1, 0, 1);
        step(3'b101, 3'b000, 1'b0, "tp3gap", 1, 0, 1);
        step(3'b111, 3'b010, 1'b0, "tp3tail", 1, 1, 1);
        step(3'b101, 3'b111, 1'b0, "tp3next", 2, 1, 0);

        do_reset("rst2");
        for (int k = 0; k < 6; k++) begin
            step(3'b100, 3'b100, 1'b1, "tp4full", 0, 0, 0, k, (k > 3) ? 3 : k);
        end
        step(3'b100, 3'b100, 1'b0, "tp4rel", 2, 1, 0, 6, 3);
        step(3'b000, 3'b000, 1'b0, "tp4clr", 0, 0, 0, 0, 0);

        do_reset("rst3");
        step(3'b001, 3'b001, 1'b0, "tp6", 0, 1, 0);
        step(3'b100, 3'b000, 1'b0, "tp6", 2, 1, 0);
        step(3'b100, 3'b000, 1'b1, "tp6", 2, 0, 1, 0);
        request = 3'b100; buffer_full_in = 1'b1;
        do_reset("tp6rst");
        step(3'b111, 3'b111, 1'b0, "tp6post", 0, 1, 0);

        burst = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(99) == 0) begin
                do_reset("rndrst");
            end else begin
                rr = N'($urandom);
                rt = N'($urandom & $urandom);
                if (burst > 0) begin
                    rf = 1'b1; burst--;
                end else if ($urandom_range(9) == 0) begin
                    rf = 1'b1; burst = $urandom_range(1, 7);
                end else begin
                    rf = ($urandom_range(5) == 0);
                end
                step(rr, rt, rf, "rnd");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_wormhole_arbiter.md
Name: rr_wormhole_arbiter

Overview:
- Per-output-port scheduler for the mesh router: shares one output port (N/S/E/W/local) among N input-port requesters.
- Requests come from the per-input DCCL route-compute blocks.
- Round-robin fair selection, with the grant locked to one requester from head flit to tail flit (wormhole).
- Honours downstream buffer_full; drives the switch mux select and the output-valid strobe.

Parameters:
- N, 3, number of requesting input ports (2..8).
- STALL_W, 8, width of the saturating back-pressure stall counter.

Ports:
- clk  in  1  router clock
- rst  in  1  asynchronous, active-high reset
- request  in  N  request[i]=1: input i has a valid flit routed to this output
- tail_i  in  N  tail_i[i]=1: current flit of input i is the packet's last (single-flit packet: head=tail)
- buffer_full_in  in  1  downstream buffer cannot accept a flit this cycle
- grant  out  N  one-hot switch select; all-zero when nothing is granted
- grant_idx_o  out  $clog2(N)  binary index of the granted input; 0 when grant=0
- grant_v_o  out  1  a flit transfers this cycle (input i dequeues, downstream enqueues)
- locked_o  out  1  arbiter is mid-packet (state LOCKED)
- stall_cnt_o  out  STALL_W  consecutive cycles with a pending request blocked by buffer_full_in; saturates

Behaviour:
- Reset (async assert, sync-safe deassert):
  - state=IDLE, ptr=0, owner=0, stall_cnt_o=0.
  - Outputs follow the combinational rules below, so with request=0: grant=0, grant_v_o=0, locked_o=0.
- grant, grant_idx_o and grant_v_o are combinational from the registered state and the current inputs: zero-cycle arbitration latency.
- State and ptr update on the clock edge.
- Transfer: xfer = grant_v_o. Every output-port move happens only on xfer.
- IDLE:
  - winner = first i with request[i]=1, searching ptr, ptr+1, ..., N-1, 0, ... (modulo N).
  - If any request and !buffer_full_in: grant=onehot(winner), grant_v_o=1.
  - If buffer_full_in: grant=0, grant_v_o=0, ptr unchanged, no commitment to winner.
  - On xfer with tail_i[winner]=1: stay IDLE, ptr <= (winner+1) mod N.
  - On xfer with tail_i[winner]=0: go to LOCKED, owner <= winner.
- LOCKED:
  - grant=onehot(owner) every cycle, regardless of other requests or buffer_full_in.
  - grant_v_o = request[owner] & !buffer_full_in.
  - Gaps (request[owner]=0) keep the lock; other inputs are never granted.
  - On xfer with tail_i[owner]=1: go to IDLE, ptr <= (owner+1) mod N.
  - Otherwise stay LOCKED.
- locked_o = (state==LOCKED).
- tail_i of non-granted inputs is ignored.
- Pointer wrap: winner N-1 gives ptr=0.
- Request-change timing: simultaneous request changes are sampled the same cycle. A new request arriving in the cycle a tail transfers is arbitrated the next cycle from the updated ptr.
- Stall counter:
  - Increments (saturating at 2^STALL_W-1) in each cycle where buffer_full_in=1 and (IDLE with any request, or LOCKED with request[owner]).
  - Clears to 0 on any xfer or when no relevant request is pending.
  - Holds at max when saturated.
- Reset mid-packet: lock and ptr are dropped immediately (async). Recovering the upstream/downstream packet is outside this block's scope.
- Illegal state encodings return to IDLE.
- Out-of-range owner (N not a power of 2) is impossible by construction; verification asserts it.
- Assertions:
  - grant is one-hot or zero.
  - grant_v_o implies request[grant_idx_o] & !buffer_full_in.
  - In LOCKED, grant is constant until the tail transfers.

Test Plan (N=3):
- Reset, request=3'b111, tail_i=3'b111, full=0 for 4 cycles -> grant_idx_o sequence 0,1,2,0; grant_v_o=1 every cycle; locked_o=0.
- request=3'b011, tail_i=3'b000 for 2 cycles, then tail_i[0]=1 -> input 0 granted 3 consecutive cycles; locked_o=1 on cycles 2-3; cycle 4 grant_idx_o=1.
- LOCKED on owner 1, request[1]=0 for 2 cycles while request[0]=request[2]=1 -> grant=3'b010, grant_v_o=0 during the gap; no other grant until input 1's tail transfers; next grant goes to input 2.
- request=3'b100, full=1 for 5 cycles, then full=0 -> grant=0, grant_v_o=0, stall_cnt_o=1..5; release cycle: grant=3'b100, grant_v_o=1, stall_cnt_o=0 the next cycle.
- STALL_W=2, full held 6 cycles with a request pending -> stall_cnt_o reads 1,2,3,3,3,3.
- rst asserted mid-packet (LOCKED, owner 2, ptr=1) -> same cycle: locked_o=0, stall_cnt_o=0. After release with request=3'b111, tail=3'b111: grant_idx_o=0.
